text_console_writer: RTL

Terminal-style writer for the 80x60 text-mode video RAM. It accepts a byte stream over a valid/ready handshake and interprets printable characters and a small set of control codes. It drives the RAM write port (din, write_en, waddr) while maintaining the cursor. It also owns screen and line clearing, so the read/display side never sees stale text.

---
 rtl/text_console_writer_if.sv | 29 ++
 rtl/text_console_writer.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/text_console_writer_if.sv
// Byte-stream handshake plus the RAM write port and cursor/status outputs of the console writer.
// The writer drives char_ready, RAM write and status signals; the source drives char_in/char_valid/clear.
interface text_console_writer_if #(
    parameter int COLS       = 80,
    parameter int ROWS       = 60,
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = $clog2(COLS*ROWS)
);
    logic [DATA_WIDTH-1:0]    char_in;
    logic                     char_valid;
    logic                     char_ready;
    logic                     clear;
    logic [DATA_WIDTH-1:0]    din;
    logic                     write_en;
    logic [ADDR_WIDTH-1:0]    waddr;
    logic [$clog2(COLS)-1:0]  cursor_col;
    logic [$clog2(ROWS)-1:0]  cursor_row;
    logic                     busy;

    modport master (
        output char_in, char_valid, clear,
        input  char_ready, din, write_en, waddr, cursor_col, cursor_row, busy
    );

    modport slave (
        input  char_in, char_valid, clear,
        output char_ready, din, write_en, waddr, cursor_col, cursor_row, busy
    );
endinterface

// File: rtl/text_console_writer.sv
// Terminal-style writer into an 80x60 text RAM; writes land one cycle after acceptance, one char/clk.
// char_ready drops whenever a line or screen clear is running or clear is requested.
module text_console_writer #(
    parameter int                    COLS           = 80,
    parameter int                    ROWS           = 60,
    parameter int                    DATA_WIDTH     = 8,
    parameter int                    ADDR_WIDTH     = $clog2(COLS*ROWS),
    parameter logic [DATA_WIDTH-1:0] BLANK          = 8'h20,
    parameter bit                    CLEAR_ON_RESET = 1'b1
) (
    input  logic                  clk,
    input  logic                  rstn,
    text_console_writer_if.slave  bus
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    localparam logic [COL_W-1:0]      COL_LAST   = COL_W'(COLS-1);
    localparam logic [ROW_W-1:0]      ROW_LAST   = ROW_W'(ROWS-1);
    localparam logic [ADDR_WIDTH-1:0] LINE_LAST  = ADDR_WIDTH'(COLS-1);
    localparam logic [ADDR_WIDTH-1:0] SCRN_LAST  = ADDR_WIDTH'(COLS*ROWS-1);
    localparam logic [ADDR_WIDTH-1:0] LINE_LEN   = ADDR_WIDTH'(COLS);
    localparam logic [ADDR_WIDTH-1:0] ADDR_ONE   = ADDR_WIDTH'(1);
    localparam logic [COL_W-1:0]      COL_ONE    = COL_W'(1);
    localparam logic [ROW_W-1:0]      ROW_ONE    = ROW_W'(1);
    localparam logic [DATA_WIDTH-1:0] C_BS       = DATA_WIDTH'(8'h08);
    localparam logic [DATA_WIDTH-1:0] C_LF       = DATA_WIDTH'(8'h0A);
    localparam logic [DATA_WIDTH-1:0] C_CR       = DATA_WIDTH'(8'h0D);
    localparam logic [DATA_WIDTH-1:0] C_PRINTMIN = DATA_WIDTH'(8'h20);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CLEAR   = 2'd1,
        S_LINECLR = 2'd2
    } state_t;

    localparam state_t RESET_STATE = CLEAR_ON_RESET ? S_CLEAR : S_IDLE;

    state_t                  state_q, state_d;
    logic [COL_W-1:0]        col_q, col_d;
    logic [ROW_W-1:0]        row_q, row_d;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
    logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0]   din_q, din_d;
    logic                    we_q, we_d;
    logic [ADDR_WIDTH-1:0]   waddr_q, waddr_d;
    logic                    busy_q, busy_d;

    logic                    ready;
    logic                    last_row;
    logic [ADDR_WIDTH-1:0]   row_start;
    logic [ADDR_WIDTH-1:0]   next_row_start;
    logic [ROW_W-1:0]        next_row;

    assign ready          = (state_q == S_IDLE) && !bus.clear;
    assign last_row       = (row_q == ROW_LAST);
    assign row_start      = addr_q - ADDR_WIDTH'(col_q);
    assign next_row_start = last_row ? '0 : row_start + LINE_LEN;
    assign next_row       = last_row ? '0 : row_q + ROW_ONE;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        din_d   = din_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;

        case (state_q)
            S_IDLE: begin
                if (bus.clear) begin
                    state_d = S_CLEAR;
                    cnt_d   = '0;
                end else if (bus.char_valid) begin
                    if (bus.char_in >= C_PRINTMIN) begin
                        we_d    = 1'b1;
                        waddr_d = addr_q;
                        din_d   = bus.char_in;
                        if (col_q == COL_LAST) begin
                            col_d   = '0;
                            row_d   = next_row;
                            addr_d  = next_row_start;
                            cnt_d   = '0;
                            state_d = S_LINECLR;
                        end else begin
                            col_d  = col_q + COL_ONE;
                            addr_d = addr_q + ADDR_ONE;
                        end
                    end else if (bus.char_in == C_LF) begin
                        col_d   = '0;
                        row_d   = next_row;
                        addr_d  = next_row_start;
                        cnt_d   = '0;
                        state_d = S_LINECLR;
                    end else if (bus.char_in == C_CR) begin
                        col_d  = '0;
                        addr_d = row_start;
                    end else if (bus.char_in == C_BS && col_q != '0) begin
                        // backspace erases the cell the cursor moves back onto
                        col_d   = col_q - COL_ONE;
                        addr_d  = addr_q - ADDR_ONE;
                        we_d    = 1'b1;
                        waddr_d = addr_q - ADDR_ONE;
                        din_d   = BLANK;
                    end
                end
            end
            S_LINECLR: begin
                // addr_q already points at column 0 of the row being blanked
                we_d    = 1'b1;
                waddr_d = addr_q + cnt_q;
                din_d   = BLANK;
                if (cnt_q == LINE_LAST) begin
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_ONE;
                end
            end
            S_CLEAR: begin
                we_d    = 1'b1;
                waddr_d = cnt_q;
                din_d   = BLANK;
                if (cnt_q == SCRN_LAST) begin
                    cnt_d   = '0;
                    col_d   = '0;
                    row_d   = '0;
                    addr_d  = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + ADDR_ONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= RESET_STATE;
            col_q   <= '0;
            row_q   <= '0;
            addr_q  <= '0;
            cnt_q   <= '0;
            din_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            busy_q  <= CLEAR_ON_RESET;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            din_q   <= din_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            busy_q  <= busy_d;
        end
    end

    assign bus.char_ready = ready;
    assign bus.din        = din_q;
    assign bus.write_en   = we_q;
    assign bus.waddr      = waddr_q;
    assign bus.cursor_col = col_q;
    assign bus.cursor_row = row_q;
    assign bus.busy       = busy_q;
endmodule
